demux_tdm: RTL and testbench

DEMUX_TDM -- requirements
Module: demux_tdm

---
 rtl/demux_tdm_pkg.sv | 23 ++
 rtl/demux_tdm_slot_counter.sv | 41 ++++
 rtl/demux_tdm.sv | 157 +++++++++++++++
 tb/tb_demux_tdm.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/demux_tdm_pkg.sv
//==============================================================================
// Module  : demux_tdm_pkg
// Purpose : Shared definitions for the TDM demultiplexer and the matching
//           4:1 mux transmitter: default slot-index width and the receiver
//           FSM state encoding (IDLE=0, RECV=1).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package demux_tdm_pkg;

    // Default slot-index width; the transmitter select uses the same value.
    localparam int SEL_W_DEF = 2;

    // Receiver FSM state encoding, fixed so both sides of the link agree.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/demux_tdm_slot_counter.sv
//==============================================================================
// Module  : slot_counter
// Purpose : SEL_W-bit slot counter. Loads 1 when a frame starts (slot 0 is
//           consumed by that same sample), increments on each further sample
//           and wraps naturally from 2**SEL_W-1 back to 0.
// Ports   : clk        - clock, rising edge
//           rst        - asynchronous active-high reset, clears count
//           i_inc      - advance to the next slot
//           i_load_one - force count to 1 (takes priority over i_inc)
//           o_cnt      - current slot index
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module slot_counter #(
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_load_one,
    output logic [SEL_W-1:0] o_cnt
);

    logic [SEL_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load_one) begin
            r_cnt <= SEL_W'(1);
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/demux_tdm.sv
//==============================================================================
// Module  : demux_tdm
// Purpose : Serial-to-parallel receiver for a 2**SEL_W slot TDM stream.
//           Bit sampled in slot k lands in D[k]. A completed word is offered
//           on D with a valid/ready handshake; words arriving while the
//           previous one is still unconsumed are dropped (sticky overrun).
//           A sync seen mid-frame restarts the frame (sticky frame_err).
// Ports   : clk       - clock, rising edge
//           rst       - asynchronous active-high reset
//           din       - serial TDM bit
//           sync      - din carries slot 0 this cycle
//           en        - sample strobe; din/sync ignored when low
//           S         - slot index expected on the next sample
//           D         - last complete word
//           valid     - D holds an unconsumed word
//           ready     - consumer accepts D when valid & ready
//           busy      - receiver is mid-frame
//           overrun   - sticky, a completed word was dropped
//           frame_err - sticky, sync arrived mid-frame
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module demux_tdm
    import demux_tdm_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               sync,
    input  logic               en,
    output logic [SEL_W-1:0]   S,
    output logic [2**SEL_W-1:0] D,
    output logic               valid,
    input  logic               ready,
    output logic               busy,
    output logic               overrun,
    output logic               frame_err
);

    localparam int N = 2**SEL_W;
    localparam logic [SEL_W-1:0] c_last_slot = SEL_W'(N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_buf;
    logic [N-1:0]     r_d;
    logic             r_valid;
    logic             r_overrun;
    logic             r_frame_err;
    logic [SEL_W-1:0] w_slot;

    logic             w_start;     // en & sync: din is slot 0 of a new frame
    logic             w_adv;       // en & !sync inside a frame
    logic             w_resync;    // sync interrupted a partial frame
    logic             w_complete;  // last slot sampled this cycle
    logic             w_load;      // completed word may enter D
    logic [N-1:0]     w_word;      // buffer with the current sample merged in

    slot_counter #(
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_adv),
        .i_load_one (w_start),
        .o_cnt      (w_slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_adv       = 1'b0;
        w_resync    = 1'b0;
        w_complete  = 1'b0;
        w_word      = r_buf;
        case (r_state)
            ST_IDLE: begin
                if (en && sync) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (en && sync) begin
                    // Restart in place; the partial word is overwritten.
                    w_start  = 1'b1;
                    w_resync = (w_slot != '0);
                end else if (en) begin
                    w_adv          = 1'b1;
                    w_word[w_slot] = din;
                    if (w_slot == c_last_slot) begin
                        w_complete  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A finished word may only replace D if D is empty or being consumed now.
    assign w_load = w_complete && (!r_valid || ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf       <= '0;
            r_d         <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_buf <= {{(N-1){1'b0}}, din};
            end else if (w_adv) begin
                r_buf <= w_word;
            end

            if (w_load) begin
                r_d     <= w_word;
                r_valid <= 1'b1;
            end else if (ready) begin
                r_valid <= 1'b0;
            end

            if (w_complete && !w_load) begin
                r_overrun <= 1'b1;
            end

            if (w_resync) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign S         = w_slot;
    assign D         = r_d;
    assign valid     = r_valid;
    assign busy      = (r_state == ST_RECV);
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_demux_tdm.sv
`default_nettype none

module tb_demux_tdm;

    logic       clk;
    logic       rst;
    logic       din;
    logic       sync;
    logic       en;
    logic       ready;
    logic [1:0] S;
    logic [3:0] D;
    logic       valid;
    logic       busy;
    logic       overrun;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    demux_tdm #(
        .SEL_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .sync      (sync),
        .en        (en),
        .S         (S),
        .D         (D),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, settle 1 time unit past the edge.
    task automatic step(input logic d, input logic s, input logic e);
        din  = d;
        sync = s;
        en   = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; sync = 1'b0; en = 1'b0; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_S", S, 0);
        chk("rst_D", D, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ferr", frame_err, 0);
        rst = 1'b0;

        // en without sync in IDLE is ignored
        step(1, 0, 1);
        chk("idle_ign_S", S, 0);
        chk("idle_ign_busy", busy, 0);

        // Single frame 1010 (slots 0..3 = 0,1,0,1)
        step(0, 1, 1); chk("f1_S1", S, 1); chk("f1_busy", busy, 1);
        step(1, 0, 1); chk("f1_S2", S, 2);
        step(0, 0, 1); chk("f1_S3", S, 3); chk("f1_nv", valid, 0);
        step(1, 0, 1); chk("f1_S0", S, 0); chk("f1_D", D, 4'b1010);
        chk("f1_valid", valid, 1); chk("f1_idle", busy, 0);
        step(0, 0, 0); chk("f1_vpulse", valid, 0);

        // Back-to-back 1010 then 0110
        step(0, 1, 1); step(1, 0, 1); step(0, 0, 1); step(1, 0, 1);
        chk("b2b_D1", D, 4'b1010); chk("b2b_v1", valid, 1);
        step(0, 1, 1); chk("b2b_cons", valid, 0); chk("b2b_S", S, 1);
        step(1, 0, 1); step(1, 0, 1); step(0, 0, 1);
        chk("b2b_D2", D, 4'b0110); chk("b2b_v2", valid, 1);
        chk("b2b_ovr", overrun, 0);
        step(0, 0, 0);

        // Backpressure: 1010 held while 1111 is dropped
        ready = 1'b0;
        step(0, 1, 1); step(1, 0, 1); step(0, 0, 1); step(1, 0, 1);
        chk("bp_D1", D, 4'b1010); chk("bp_v1", valid, 1);
        step(1, 1, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        chk("bp_Dhold", D, 4'b1010); chk("bp_vhold", valid, 1);
        chk("bp_ovr", overrun, 1);
        ready = 1'b1;
        step(0, 0, 0);
        chk("bp_drain", valid, 0); chk("bp_ovr_sticky", overrun, 1);

        // Resync: sync at S=2 with din=1, then 1,1,1
        chk("rs_ferr0", frame_err, 0);
        step(1, 1, 1); step(0, 0, 1);
        chk("rs_S2", S, 2);
        step(1, 1, 1);
        chk("rs_ferr", frame_err, 1); chk("rs_S1", S, 1); chk("rs_busy", busy, 1);
        step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        chk("rs_D", D, 4'b1111); chk("rs_valid", valid, 1);
        step(0, 0, 0);

        // en gating: 3-cycle gap between slots 1 and 2 of 1010
        step(0, 1, 1); step(1, 0, 1);
        chk("gt_S2", S, 2);
        step(1, 1, 0); chk("gt_hold1", S, 2);
        step(1, 0, 0); chk("gt_hold2", S, 2);
        step(1, 1, 0); chk("gt_hold3", S, 2); chk("gt_busy", busy, 1);
        step(0, 0, 1); step(1, 0, 1);
        chk("gt_D", D, 4'b1010); chk("gt_valid", valid, 1);
        chk("gt_ferr_sticky", frame_err, 1);
        step(0, 0, 0);

        // Asynchronous reset mid-frame, no clock edge needed
        step(1, 1, 1); step(1, 0, 1);
        chk("ar_pre_S", S, 2);
        #2 rst = 1'b1;
        #1;
        chk("ar_S", S, 0); chk("ar_D", D, 0); chk("ar_valid", valid, 0);
        chk("ar_busy", busy, 0); chk("ar_ovr", overrun, 0); chk("ar_ferr", frame_err, 0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 1); step(1, 0, 1); step(0, 0, 1); step(1, 0, 1);
        chk("ar_fresh_D", D, 4'b1010); chk("ar_fresh_v", valid, 1);
        chk("ar_fresh_ferr", frame_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
